// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating group accumulator for multiplier products
//
// Purpose: sums up to N_TERMS unsigned 8-bit products arriving on a
// valid/ready stream (a group may end early on in_last), then presents the
// saturated sum, the term count and a sticky overflow flag on a valid/ready
// output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear, discards the current group or result
//   in_valid   product beat valid
//   in_ready   block accepts a product this cycle
//   in_prod    8-bit unsigned product
//   in_last    final product of a short group (accepted beats only)
//   out_valid  group result available
//   out_ready  downstream accepts the result
//   out_sum    group sum, saturating (0 when out_valid=0)
//   out_count  products in the group (0 when out_valid=0)
//   out_ovf    sum saturated in this group (0 when out_valid=0)
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX   = '1;
  localparam logic [4:0]       N_TERMS_V = 5'(N_TERMS);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  // Cleared by reset and set on the first clock edge after release, so
  // in_ready stays low during reset and rises only on a clock edge.
  logic             run_q;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic [4:0]       cnt_inc;

  assign in_ready  = run_q && (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // One spare bit catches the carry that signals saturation.
  assign sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_prod};
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        // IDLE holds acc=0/cnt=0, so the first beat shares the ACCUM update.
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_d   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
            ovf_d   = ovf_q | sum[ACC_W];
            cnt_d   = cnt_inc[3:0];
            state_d = (cnt_inc == N_TERMS_V || in_last) ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      run_q   <= 1'b1;
    end
  end

  assign out_sum   = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : 4'd0;
  assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed bench for product_accumulator
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, in_valid, in_last, out_ready;
  logic [7:0] in_prod;
  logic       in_ready, out_valid, out_ovf;
  logic [9:0] out_sum;
  logic [3:0] out_count;

  logic       b_clr, b_in_valid, b_in_last, b_out_ready;
  logic [7:0] b_in_prod;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0] b_out_sum;
  logic [3:0] b_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  product_accumulator #(.N_TERMS(3), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  // Starts at a negedge; drives one beat, waits (bounded) for in_ready,
  // and returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] p, input logic l);
    int n = 0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready got %0b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_main_group();
    send(8'd50, 1'b0); send(8'd104, 1'b0); send(8'd48, 1'b0); send(8'd210, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 0; in_valid = 0; in_last = 0; in_prod = 0; out_ready = 0;
    b_clr = 0; b_in_valid = 0; b_in_last = 0; b_in_prod = 0; b_out_ready = 0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_hs got rdy=%0b vld=%0b want 0/0", in_ready, out_valid); end
    checks++; if (out_sum !== 10'd0 || out_count !== 4'd0 || out_ovf !== 1'b0) begin errors++;
      $display("FAIL reset_out got sum=%0d cnt=%0d ovf=%0b want 0/0/0", out_sum, out_count, out_ovf); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL release_before_edge in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++;
      $display("FAIL release_after_edge got %0b/%0b want 1/1", in_ready, b_in_ready); end
  endtask

  task automatic test_main();
    out_ready = 1'b1;
    send(8'd50, 1'b0);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL main_accum got rdy=%0b vld=%0b want 1/0", in_ready, out_valid); end
    send(8'd104, 1'b0); send(8'd48, 1'b0); send(8'd210, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL main_latency got vld=%0b rdy=%0b want 1/0", out_valid, in_ready); end
    checks++; if (out_sum !== 10'd412 || out_count !== 4'd4 || out_ovf !== 1'b0) begin errors++;
      $display("FAIL main_result got sum=%0d cnt=%0d ovf=%0b want 412/4/0", out_sum, out_count, out_ovf); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0) begin errors++;
      $display("FAIL main_return got vld=%0b rdy=%0b sum=%0d want 0/1/0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_early_last();
    out_ready = 1'b1;
    send(8'd105, 1'b0); send(8'd60, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd165 || out_count !== 4'd2 || out_ovf !== 1'b0) begin errors++;
      $display("FAIL early_last got vld=%0b sum=%0d cnt=%0d ovf=%0b want 1/165/2/0", out_valid, out_sum, out_count, out_ovf); end
    @(negedge clk);
    send(8'd77, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd77 || out_count !== 4'd1) begin errors++;
      $display("FAIL one_term got vld=%0b sum=%0d cnt=%0d want 1/77/1", out_valid, out_sum, out_count); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    logic [7:0] prods [3];
    prods[0] = 8'd210; prods[1] = 8'd210; prods[2] = 8'd165;
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_prod = prods[i];
      @(posedge clk); @(negedge clk);
    end
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_out_sum !== 8'd255 || b_out_ovf !== 1'b1 || b_out_count !== 4'd3) begin errors++;
      $display("FAIL saturate got vld=%0b sum=%0d ovf=%0b cnt=%0d want 1/255/1/3", b_out_valid, b_out_sum, b_out_ovf, b_out_count); end
    b_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b0 || b_out_ovf !== 1'b0 || b_in_ready !== 1'b1) begin errors++;
      $display("FAIL saturate_clear got vld=%0b ovf=%0b rdy=%0b want 0/0/1", b_out_valid, b_out_ovf, b_in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_main_group();
    in_valid = 1'b1; in_prod = 8'd100; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sum !== 10'd412 || out_count !== 4'd4 || in_ready !== 1'b0) begin errors++;
        $display("FAIL bp_hold[%0d] got vld=%0b sum=%0d cnt=%0d rdy=%0b want 1/412/4/0", i, out_valid, out_sum, out_count, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release got vld=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    @(posedge clk); @(negedge clk);
    send(8'd1, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd101 || out_count !== 4'd2) begin errors++;
      $display("FAIL bp_next_group got vld=%0b sum=%0d cnt=%0d want 1/101/2", out_valid, out_sum, out_count); end
    @(negedge clk);
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    send(8'd50, 1'b0); send(8'd104, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 8'd48;
    @(posedge clk); @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL clr_idle got vld=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) send(8'd16, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd64 || out_count !== 4'd4) begin errors++;
      $display("FAIL clr_next got vld=%0b sum=%0d cnt=%0d want 1/64/4", out_valid, out_sum, out_count); end
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd7, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL clr_done got vld=%0b sum=%0d rdy=%0b want 0/0/1", out_valid, out_sum, in_ready); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(8'd50, 1'b0); send(8'd104, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL areset_accum got rdy=%0b vld=%0b want 0/0", in_ready, out_valid); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_main_group();
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL areset_pre_done out_valid got %0b want 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_count !== 4'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL areset_done got vld=%0b sum=%0d cnt=%0d ovf=%0b rdy=%0b want all 0", out_valid, out_sum, out_count, out_ovf, in_ready); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL areset_release in_ready got %0b want 1", in_ready); end
    out_ready = 1'b1;
    send_main_group();
    checks++; if (out_valid !== 1'b1 || out_sum !== 10'd412 || out_count !== 4'd4) begin errors++;
      $display("FAIL areset_group got vld=%0b sum=%0d cnt=%0d want 1/412/4", out_valid, out_sum, out_count); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_main();
    test_early_last();
    test_saturate();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
